// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with hex decode, leading-zero blanking and double-buffered display value.
// Latency: pins are registered, one cycle behind the scan state and the live inputs; a load reaches the display within one frame + 1 cycle.
// Backpressure: none; load is a fire-and-forget strobe, repeated loads before a frame boundary overwrite the pending value.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           div_cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_reg;
  logic [4*NUM_DIGITS-1:0] disp_reg;

  logic                  slot_end;
  logic                  boundary;
  logic [3:0]            nib;
  logic                  en_sel;
  logic                  dp_sel;
  logic                  blank_sel;
  logic                  zero_above;
  logic                  in_blank;
  logic                  active;
  logic [NUM_DIGITS-1:0] an_nxt;

  assign slot_end = (div_cnt == DIV_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot divider and digit index: idx advances once per REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // Double buffer: disp_reg only changes at a frame boundary so a frame never mixes two values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
      disp_reg <= '0;
      pending  <= 1'b0;
    end else if (boundary && load) begin
      disp_reg <= value;
      pending  <= 1'b0;
    end else if (boundary && pending) begin
      disp_reg <= pend_reg;
      pending  <= 1'b0;
    end else if (load) begin
      pend_reg <= value;
      pending  <= 1'b1;
    end
  end

  // Select the current digit's nibble and masks; a digit is a leading zero when it and all digits above it are zero.
  always_comb begin
    nib        = '0;
    en_sel     = 1'b0;
    dp_sel     = 1'b0;
    blank_sel  = 1'b0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_reg[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nib       = disp_reg[4*i +: 4];
        en_sel    = digit_en[i];
        dp_sel    = dp_in[i];
        blank_sel = lz_blank && (i != 0) && zero_above;
      end
    end
    in_blank = (int'(div_cnt) < BLANK_CYCLES);
    active   = !in_blank && en_sel;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_nxt[i] = !(active && (idx == IW'(i)));
    end
  end

  // Output pin registers; segments and dp are forced dark whenever no anode is driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      seg        <= '1;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= (active && !blank_sel) ? hex7(nib) : 7'h7F;
      dp         <= active ? !dp_sel : 1'b1;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a small slot size; a time-based model predicts every pin every cycle.
// Table of load values checks decode and blanking; hand sequences cover buffering, masks and mid-scan reset.
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value;
  logic          load;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic          lz_blank;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_tick;
  logic          pending;

  seg7_scan_driver #(.NUM_DIGITS(D), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .an(an), .seg(seg), .dp(dp),
    .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: absolute cycle count since reset plus the two buffers
  int          n;
  logic [15:0] m_disp, m_pend;
  bit          m_pending;
  logic [6:0]  segtab [16];

  logic [6:0]  obs [4];
  int          tick_cnt, bad_an_cnt, dp0_cnt, dp_wrong_cnt;

  typedef struct {
    logic [15:0]      v;
    logic             lz;
    logic [3:0][6:0]  s;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // one clock: predict pins from model state + current inputs, advance model, compare after the edge
  task automatic cyc();
    int slot, pos;
    bit bnd, act, blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_tick;
    logic [15:0] above;
    slot = (n / R) % D;
    pos  = n % R;
    bnd  = (pos == R - 1) && (slot == D - 1);
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
      n = 0; m_disp = '0; m_pend = '0; m_pending = 0;
    end else begin
      act    = (pos >= B) && digit_en[slot];
      above  = m_disp >> (4 * slot);
      blank  = lz_blank && (slot != 0) && (above == 16'h0);
      e_an   = act ? ~(4'b0001 << slot) : 4'hF;
      e_seg  = (act && !blank) ? segtab[above[3:0]] : 7'h7F;
      e_dp   = act ? ~dp_in[slot] : 1'b1;
      e_tick = bnd;
      if (bnd && load) begin m_disp = value; m_pending = 0; end
      else if (bnd && m_pending) begin m_disp = m_pend; m_pending = 0; end
      else if (load) begin m_pend = value; m_pending = 1; end
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("seg", {9'h0, seg}, {9'h0, e_seg});
    chk("dp", {15'h0, dp}, {15'h0, e_dp});
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, e_tick});
    chk("pending", {15'h0, pending}, {15'h0, m_pending});
    for (int i = 0; i < D; i++) if (an[i] == 1'b0) obs[i] = seg;
    if (frame_tick) tick_cnt++;
    if (an[1] == 1'b0 || an[3] == 1'b0) bad_an_cnt++;
    if (dp == 1'b0) dp0_cnt++;
    if (dp == 1'b0 && an != 4'b1101) dp_wrong_cnt++;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic clr();
    for (int i = 0; i < D; i++) obs[i] = 'x;
    tick_cnt = 0; bad_an_cnt = 0; dp0_cnt = 0; dp_wrong_cnt = 0;
  endtask

  task automatic wait_to(input int s, input int p);
    for (int k = 0; k < 4 * D * R && !(((n / R) % D) == s && (n % R) == p); k++) cyc();
    chk("wait_to_phase", 16'(((n / R) % D) * R + n % R), 16'(s * R + p));
  endtask

  task automatic chk_digits(input string nm, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    chk({nm, "_d3"}, {9'h0, obs[3]}, {9'h0, e3});
    chk({nm, "_d2"}, {9'h0, obs[2]}, {9'h0, e2});
    chk({nm, "_d1"}, {9'h0, obs[1]}, {9'h0, e1});
    chk({nm, "_d0"}, {9'h0, obs[0]}, {9'h0, e0});
  endtask

  initial begin
    segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    tbl[0] = '{16'h12AF, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
    tbl[1] = '{16'h0030, 1'b1, {7'h7F, 7'h7F, 7'b0110000, 7'b1000000}};
    tbl[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}};
    tbl[3] = '{16'h0000, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    tbl[4] = '{16'h89CD, 1'b0, {7'b0000000, 7'b0010000, 7'b1000110, 7'b0100001}};
    tbl[5] = '{16'h3E6B, 1'b1, {7'b0110000, 7'b0000110, 7'b0000010, 7'b0000011}};
    tbl[6] = '{16'h740F, 1'b1, {7'b1111000, 7'b0011001, 7'b1000000, 7'b0001110}};
    tbl[7] = '{16'h5555, 1'b0, {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}};

    n = 0; m_disp = '0; m_pend = '0; m_pending = 0;
    clr();

    // reset held with a load pending on the inputs
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    dp_in = 4'h0; digit_en = 4'hF; lz_blank = 1'b0;
    @(negedge clk);
    run(3);
    rst = 1'b0; load = 1'b0;
    clr();
    run(D * R);
    chk("post_reset_digit0", {9'h0, obs[0]}, 16'h0040);

    // decode / blanking table
    for (int t = 0; t < 8; t++) begin
      lz_blank = tbl[t].lz;
      value = tbl[t].v; load = 1'b1;
      cyc();
      load = 1'b0;
      clr();
      run(D * R);
      chk("tbl_ticks_first_frame", 16'(tick_cnt), 16'd1);
      clr();
      run(D * R);
      chk_digits($sformatf("tbl%0d", t), tbl[t].s[3], tbl[t].s[2], tbl[t].s[1], tbl[t].s[0]);
    end

    // double buffering: two loads mid-frame, last one wins at the boundary
    lz_blank = 1'b0;
    wait_to(1, 3);
    value = 16'h5555; load = 1'b1; cyc(); load = 1'b0;
    chk("pending_after_load", {15'h0, pending}, 16'h1);
    wait_to(2, 0);
    value = 16'h7777; load = 1'b1; cyc(); load = 1'b0;
    wait_to(0, 0);
    chk("pending_after_boundary", {15'h0, pending}, 16'h0);
    clr();
    run(D * R);
    chk_digits("dbuf", 7'b1111000, 7'b1111000, 7'b1111000, 7'b1111000);

    // load exactly at the frame boundary
    wait_to(D - 1, R - 1);
    value = 16'h3333; load = 1'b1; cyc(); load = 1'b0;
    chk("pending_bnd_load", {15'h0, pending}, 16'h0);
    clr();
    run(D * R);
    chk_digits("bnd_load", 7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000);

    // masks
    digit_en = 4'b0101; dp_in = 4'b0010;
    clr();
    run(D * R);
    chk("mask_an_disabled", 16'(bad_an_cnt), 16'd0);
    chk("mask_dp_disabled", 16'(dp0_cnt), 16'd0);
    digit_en = 4'hF;
    cyc();
    clr();
    run(D * R);
    chk("dp_only_digit1", 16'(dp_wrong_cnt), 16'd0);
    chk("dp_lit_cycles", 16'(dp0_cnt), 16'(R - B));
    dp_in = 4'h0;

    // reset mid-scan while a value is pending
    wait_to(1, 0);
    value = 16'h9999; load = 1'b1; cyc(); load = 1'b0;
    wait_to(2, 3);
    chk("pending_before_rst", {15'h0, pending}, 16'h1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_pending", {15'h0, pending}, 16'h0);
    clr();
    run(2 * D * R);
    chk_digits("after_rst", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 15) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        dp_in    = 4'($urandom);
        digit_en = 4'($urandom);
        lz_blank = 1'($urandom);
      end
      rst = ($urandom_range(0, 249) == 0);
      cyc();
    end
    rst = 1'b0; load = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It takes a packed hex value and per-digit decimal-point and enable masks, and scans the digits one at a time. It decodes each nibble to active-low segments, with optional leading-zero blanking and an anti-ghosting blank interval. New values are double-buffered so the display never tears mid-frame. It sits between the ALU result/status registers and the board's segment/anode pins.

## Interface
- NUM_DIGITS, default 4: digits driven; legal 1..8.
- REFRESH_DIV, default 100000: clock cycles per digit slot; must be ≥ BLANK_CYCLES+2.
- BLANK_CYCLES, default 2: cycles at the start of each slot with all anodes off; legal ≥ 0.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 is rightmost.
- load  in  1  single-cycle strobe that captures value into the pending buffer.
- dp_in  in  NUM_DIGITS  decimal point request per digit; 1 = lit. Sampled live.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 = anode held off. Sampled live.
- lz_blank  in  1  1 = blank leading zeros. Sampled live.
- an  out  NUM_DIGITS  anodes, active-low; at most one bit low at any time.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- pending  out  1  high while a loaded value awaits transfer.

## Operation
- State: div_cnt (0..REFRESH_DIV-1), idx (0..NUM_DIGITS-1), pend_reg, disp_reg, pending flag.
- div_cnt increments every cycle and wraps at REFRESH_DIV-1. On a wrap, idx increments; NUM_DIGITS-1 wraps to 0.
- Frame boundary: the cycle where div_cnt wraps and idx = NUM_DIGITS-1.
- Double buffering:
  - load writes pend_reg and sets pending. Repeated loads overwrite; last wins.
  - At a frame boundary with pending=1: disp_reg ← pend_reg and pending clears.
  - load coinciding with a frame boundary: value goes directly to disp_reg and pending stays 0.
- Decode of the selected nibble, {g..a} active-low:
  - 0 1000000; 1 1111001; 2 0100100; 3 0110000
  - 4 0011001; 5 0010010; 6 0000010; 7 1111000
  - 8 0000000; 9 0010000; A 0001000; b 0000011
  - C 1000110; d 0100001; E 0000110; F 0001110
- Leading-zero blanking: when lz_blank=1, every digit above the most significant nonzero digit of disp_reg shows seg=1111111. Digit 0 is never blanked, so value 0 shows "0". dp is unaffected by blanking.
- Anode for digit idx is low only when div_cnt ≥ BLANK_CYCLES and digit_en[idx]=1; otherwise all anodes are high. A disabled digit still consumes its slot.
- dp = ~dp_in[idx] while the anode is active, otherwise 1. seg is forced to 1111111 whenever no anode is active.

## Timing
- Reset values:
  - an all ones; seg 1111111; dp 1; frame_tick 0; pending 0.
  - div_cnt 0; idx 0; disp_reg 0; pend_reg 0.
- an, seg, dp and frame_tick are registered, with one cycle of latency from state (div_cnt, idx, disp_reg) to pins. frame_tick is high in the cycle after the frame boundary.
- A frame is NUM_DIGITS*REFRESH_DIV cycles. Within a slot the anode is low for REFRESH_DIV-BLANK_CYCLES cycles.
- The load-to-display latency is at most one frame + 1 cycle. A change of disp_reg takes effect starting with digit 0's slot.
- rst mid-scan: on the next edge all state and outputs return to reset values and any pending value is discarded. After rst deasserts, scanning restarts at idx 0, div_cnt 0.
- Live inputs (dp_in, digit_en, lz_blank) affect pins with 1-cycle latency, even mid-slot.

## Test plan
- Reset: hold rst 3 cycles with load=1 and value=16'hFFFF -> an=4'hF, seg=7'h7F, dp=1, pending=0, frame_tick=0 throughout. The first post-reset frame shows 0 on digit 0.
- Scan and decode (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; load 16'h12AF, wait one frame):
  - slot 0: an=1110, seg=0001110 for 6 cycles after 2 blank cycles (an=1111, seg=1111111).
  - slots 1–3: an=1101/seg=0001000, an=1011/seg=0100100, an=0111/seg=1111001.
  - frame_tick every 32 cycles.
- Leading-zero blanking: lz_blank=1 with 16'h0030 -> digits 3 and 2 show 1111111, digit 1 shows 0110000, digit 0 shows 1000000. With 16'h0000, only digit 0 shows 1000000.
- Double buffering: load 16'h5555 at slot 1 cycle 3, then 16'h7777 at slot 2 -> pending=1 and pins keep the old value until the boundary. Then pending=0 and all digits show 1111000. A load at the exact boundary cycle -> immediate update with pending staying 0.
- Masks: digit_en=4'b0101, dp_in=4'b0010 -> an never drives bits 1 or 3 low, and dp is never 0 (the dp digit is disabled). With digit_en=4'hF, dp=0 only while an=1101.
- Reset mid-scan: assert rst during slot 2 with pending=1 -> next cycle outputs at reset values. After release, disp_reg=0 and the pending value is never displayed.
